mux_n_pipe: RTL and testbench

Parametrised N:1 select block with a registered, valid/ready-handshaked output. It is the next-generation replacement for the fixed 3:1 combinational mux used in the datapath's operand/writeback select paths. The block adds width and input-count generalisation, a defined output for out-of-range selects, a two-entry skid buffer for backpressure, and flush support for pipeline redirect.

---
 rtl/riscv_mux_pkg.sv | 23 ++
 rtl/pipe_skid_buf.sv | 94 +++++++++
 rtl/mux_n_pipe.sv | 92 +++++++++
 tb/tb_mux_n_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mux_pkg.sv
// Shared types for the N:1 select pipe: buffer state encoding, beat layout and limits.
package riscv_mux_pkg;

  localparam int MUX_MAX_IN      = 16;
  localparam int MUX_BEAT_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } mux_buf_state_e;

  // Default-width view of a buffered beat; the top builds the same layout at its own WIDTH.
  typedef struct packed {
    logic [MUX_BEAT_DATA_W-1:0] data;
    logic                       err;
  } mux_beat_t;

  function automatic int mux_beat_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready buffer (output register plus one skid entry) with flush.
module pipe_skid_buf
  import riscv_mux_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  mux_buf_state_e r_state;
  mux_buf_state_e w_next;
  logic           r_in_ready;
  logic [W-1:0]   r_out;
  logic [W-1:0]   r_skid;
  logic           w_accept;
  logic           w_load_out_in;
  logic           w_load_out_skid;
  logic           w_load_skid;

  assign w_accept = in_valid && r_in_ready;

  always_comb begin
    w_next          = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next        = ONE;
          w_load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && out_ready) begin
          w_load_out_in = 1'b1;
        end else if (w_accept) begin
          w_next      = TWO;
          w_load_skid = 1'b1;
        end else if (out_ready) begin
          w_next = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          w_next          = ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_next = EMPTY;
    endcase
    // Flush overrides everything, including a beat offered this cycle.
    if (flush) begin
      w_next          = EMPTY;
      w_load_out_in   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
    end
  end

  // in_ready is registered from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
      if (w_load_out_in) begin
        r_out <= in_data;
      end else if (w_load_out_skid) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_out;

endmodule

// File: rtl/mux_n_pipe.sv
// Parametrised N:1 select with registered, skid-buffered valid/ready output.
// Optional transfer/error counters are enabled with `define MUX_N_PIPE_STATS_EN.
module mux_n_pipe
  import riscv_mux_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    sel_err
`ifdef MUX_N_PIPE_STATS_EN
  ,
  output logic [31:0]             beat_cnt,
  output logic [15:0]             err_cnt
`endif
);

  localparam int N_EFF = (NUM_IN > MUX_MAX_IN) ? MUX_MAX_IN : NUM_IN;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  logic             w_sel_err;
  logic [WIDTH-1:0] w_sel_data;
  beat_t            w_beat_in;
  beat_t            w_beat_out;

  assign w_sel_err = (32'(sel) >= NUM_IN);

  // Out-of-range selects match no input and fall through to zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_EFF; k++) begin
      if (32'(sel) == k) begin
        w_sel_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_beat_in = '{data: w_sel_data, err: w_sel_err};

  pipe_skid_buf #(
    .W(mux_beat_w(WIDTH))
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (w_beat_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_beat_out)
  );

  assign dout    = w_beat_out.data;
  assign sel_err = w_beat_out.err;

`ifdef MUX_N_PIPE_STATS_EN
  logic [31:0] r_beat_cnt;
  logic [15:0] r_err_cnt;

  // Counters track output handshakes only, so a flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (out_valid && out_ready) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
      if (sel_err) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign err_cnt  = r_err_cnt;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Scoreboard bench for mux_n_pipe: a 3-input 32-bit instance and a 12-input 8-bit instance.
module tb_mux_n_pipe;

  logic clk;
  logic rst;

  // Instance A: NUM_IN=3, WIDTH=32
  logic        aFlush, aInValid, aInReady, aOutValid, aOutReady, aSelErr;
  logic [1:0]  aSel;
  logic [95:0] aDin;
  logic [31:0] aDout;

  // Instance B: NUM_IN=12, WIDTH=8
  logic        bFlush, bInValid, bInReady, bOutValid, bOutReady, bSelErr;
  logic [3:0]  bSel;
  logic [95:0] bDin;
  logic [7:0]  bDout;
`ifdef MUX_N_PIPE_STATS_EN
  logic [31:0] aBeatCnt, bBeatCnt;
  logic [15:0] aErrCnt, bErrCnt;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } expA_t;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } expB_t;

  expA_t qA[$];
  expB_t qB[$];

  int nVectors     = 0;
  int nMiscompares = 0;

  logic        aPrevHold, bPrevHold;
  logic [31:0] aPrevDout;
  logic [7:0]  bPrevDout;
  logic        aPrevErr, bPrevErr;

  logic [95:0] dA;
  int selsB[20] = '{0, 1, 15, 2, 3, 4, 15, 5, 6, 7, 8, 15, 9, 10, 11, 0, 15, 3, 7, 11};

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) dutA (
    .clk      (clk),
    .rst      (rst),
    .flush    (aFlush),
    .in_valid (aInValid),
    .in_ready (aInReady),
    .sel      (aSel),
    .din      (aDin),
    .out_valid(aOutValid),
    .out_ready(aOutReady),
    .dout     (aDout),
    .sel_err  (aSelErr)
`ifdef MUX_N_PIPE_STATS_EN
    ,
    .beat_cnt (aBeatCnt),
    .err_cnt  (aErrCnt)
`endif
  );

  mux_n_pipe #(.WIDTH(8), .NUM_IN(12)) dutB (
    .clk      (clk),
    .rst      (rst),
    .flush    (bFlush),
    .in_valid (bInValid),
    .in_ready (bInReady),
    .sel      (bSel),
    .din      (bDin),
    .out_valid(bOutValid),
    .out_ready(bOutReady),
    .dout     (bDout),
    .sel_err  (bSelErr)
`ifdef MUX_N_PIPE_STATS_EN
    ,
    .beat_cnt (bBeatCnt),
    .err_cnt  (bErrCnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle on instance A; expected beat is queued only if it should be accepted.
  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic rdy, input logic fl,
                               input logic expReady, input logic [31:0] expData, input logic expErr);
    @(posedge clk);
    #1;
    aInValid  = v;
    aSel      = s;
    aDin      = dA;
    aOutReady = rdy;
    aFlush    = fl;
    @(negedge clk);
    if (v) checkOutput("A in_ready", 32'(aInReady), 32'(expReady));
    if (fl) qA.delete();
    else if (v && expReady) qA.push_back('{data: expData, err: expErr});
  endtask

  task automatic applyStimulusB(input logic v, input logic [3:0] s, input logic fl);
    @(posedge clk);
    #1;
    bInValid = v;
    bSel     = s;
    bFlush   = fl;
    @(negedge clk);
    if (v) checkOutput("B in_ready", 32'(bInReady), 32'd1);
    if (fl) qB.delete();
    else if (v) begin
      if (s < 4'd12) qB.push_back('{data: 8'(8'h10 + 8'(s)), err: 1'b0});
      else           qB.push_back('{data: 8'h00, err: 1'b1});
    end
  endtask

  // Monitor for instance A: holding stability and in-order scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      aPrevHold = 1'b0;
    end else begin
      if (aOutValid && aPrevHold) begin
        checkOutput("A hold dout", aDout, aPrevDout);
        checkOutput("A hold sel_err", 32'(aSelErr), 32'(aPrevErr));
      end
      if (aOutValid && aOutReady) begin
        if (qA.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL A unexpected beat: got %h, expected no beat at %0t", aDout, $time);
        end else begin
          expA_t e;
          e = qA.pop_front();
          checkOutput("A dout", aDout, e.data);
          checkOutput("A sel_err", 32'(aSelErr), 32'(e.err));
        end
      end
      aPrevHold = aOutValid && !aOutReady;
      aPrevDout = aDout;
      aPrevErr  = aSelErr;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst) begin
      bPrevHold = 1'b0;
    end else begin
      if (bOutValid && bPrevHold) begin
        checkOutput("B hold dout", 32'(bDout), 32'(bPrevDout));
        checkOutput("B hold sel_err", 32'(bSelErr), 32'(bPrevErr));
      end
      if (bOutValid && bOutReady) begin
        if (qB.size() == 0) begin
          nVectors++;
          nMiscompares++;
          $display("[TB] FAIL B unexpected beat: got %h, expected no beat at %0t", bDout, $time);
        end else begin
          expB_t e;
          e = qB.pop_front();
          checkOutput("B dout", 32'(bDout), 32'(e.data));
          checkOutput("B sel_err", 32'(bSelErr), 32'(e.err));
        end
      end
      bPrevHold = bOutValid && !bOutReady;
      bPrevDout = bDout;
      bPrevErr  = bSelErr;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    rst       = 1'b1;
    aFlush    = 1'b0; aInValid = 1'b0; aOutReady = 1'b1; aSel = '0; aDin = '0;
    bFlush    = 1'b0; bInValid = 1'b0; bOutReady = 1'b1; bSel = '0; bDin = '0;
    aPrevHold = 1'b0; bPrevHold = 1'b0;
    aPrevDout = '0; bPrevDout = '0; aPrevErr = 1'b0; bPrevErr = 1'b0;
    dA = {32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
    for (int k = 0; k < 12; k++) bDin[k*8 +: 8] = 8'(16 + k);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset out_valid", 32'(aOutValid), 32'd0);
    checkOutput("reset dout", aDout, 32'd0);
    checkOutput("reset sel_err", 32'(aSelErr), 32'd0);
    checkOutput("reset in_ready", 32'(aInReady), 32'd1);
    checkOutput("reset B out_valid", 32'(bOutValid), 32'd0);

    // Back-to-back selects with no backpressure
    applyStimulus(1, 2'd0, 1, 0, 1, 32'hA, 0);
    applyStimulus(1, 2'd1, 1, 0, 1, 32'hB, 0);
    applyStimulus(1, 2'd2, 1, 0, 1, 32'hC, 0);
    repeat (3) applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);

    // Out-of-range select, then a good one
    applyStimulus(1, 2'd3, 1, 0, 1, 32'h0, 1);
    applyStimulus(1, 2'd1, 1, 0, 1, 32'hB, 0);
    repeat (3) applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);

    // Backpressure fills both entries, a third beat is refused
    applyStimulus(1, 2'd0, 0, 0, 1, 32'hA, 0);
    applyStimulus(1, 2'd1, 0, 0, 1, 32'hB, 0);
    applyStimulus(1, 2'd2, 0, 0, 0, 32'hC, 0);
    checkOutput("TWO dout", aDout, 32'hA);
    applyStimulus(0, 2'd0, 0, 0, 0, 32'h0, 0);
    checkOutput("TWO in_ready", 32'(aInReady), 32'd0);
    applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);
    applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);
    checkOutput("drain in_ready", 32'(aInReady), 32'd1);
    repeat (2) applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);

    // Flush in TWO with a beat offered
    applyStimulus(1, 2'd0, 0, 0, 1, 32'hA, 0);
    applyStimulus(1, 2'd1, 0, 0, 1, 32'hB, 0);
    applyStimulus(1, 2'd2, 0, 1, 0, 32'hC, 0);
    applyStimulus(0, 2'd0, 0, 0, 1, 32'h0, 0);
    checkOutput("flush out_valid", 32'(aOutValid), 32'd0);
    checkOutput("flush in_ready", 32'(aInReady), 32'd1);

    // Flush in ONE while in_ready=1: the offered beat must still be dropped
    applyStimulus(1, 2'd0, 0, 0, 1, 32'hA, 0);
    applyStimulus(1, 2'd2, 0, 1, 1, 32'hC, 0);
    applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);
    checkOutput("flush ONE out_valid", 32'(aOutValid), 32'd0);
    repeat (2) applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);

    // Reset while a beat is stalled on the output
    applyStimulus(1, 2'd0, 0, 0, 1, 32'hA, 0);
    applyStimulus(0, 2'd0, 0, 0, 1, 32'h0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    qA.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst out_valid", 32'(aOutValid), 32'd0);
    checkOutput("rst dout", aDout, 32'd0);
    checkOutput("rst sel_err", 32'(aSelErr), 32'd0);
    checkOutput("rst in_ready", 32'(aInReady), 32'd1);
    repeat (3) applyStimulus(0, 2'd0, 1, 0, 1, 32'h0, 0);

    // Instance B: 20 beats, four with sel=15 against NUM_IN=12
    for (int i = 0; i < 20; i++) applyStimulusB(1, 4'(selsB[i]), 0);
    repeat (3) applyStimulusB(0, 4'd0, 0);
`ifdef MUX_N_PIPE_STATS_EN
    checkOutput("B beat_cnt", bBeatCnt, 32'd20);
    checkOutput("B err_cnt", 32'(bErrCnt), 32'd4);
    applyStimulusB(1, 4'd1, 1);
    applyStimulusB(0, 4'd0, 0);
    checkOutput("B beat_cnt after flush", bBeatCnt, 32'd20);
    checkOutput("B err_cnt after flush", 32'(bErrCnt), 32'd4);
    checkOutput("A err_cnt", 32'(aErrCnt), 32'd0);
`endif

    guard = 0;
    while ((qA.size() != 0 || qB.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("scoreboard drained", 32'(qA.size() + qB.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
